ahb_cpu_master: RTL and testbench

//  AHB initiator that turns a simple CPU load/store req/ack interface into single AHB transfers.

---
 rtl/ahb_pkg.sv | 35 +++
 rtl/ahb_mst_align_chk.sv | 21 ++
 rtl/ahb_cpu_master.sv | 168 ++++++++++++++++
 tb/tb_ahb_cpu_master.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: bus widths, HTRANS/HRESP encodings, HSIZE/HBURST constants
// and the CPU-master FSM state type.
package ahb_pkg;

  localparam int unsigned AHB_ADDR_BITS = 32;
  localparam int unsigned AHB_DATA_BITS = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR2,
    ST_RTRY
  } mst_state_e;

endpackage

// File: rtl/ahb_mst_align_chk.sv
// Combinational size/address alignment check for the AHB CPU master.
// Byte is always aligned; half needs addr[0]=0; word needs addr[1:0]=0; larger sizes are rejected.
module ahb_mst_align_chk
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      HSIZE_BYTE: misaligned = 1'b0;
      HSIZE_HALF: misaligned = addr_lo[0];
      HSIZE_WORD: misaligned = (addr_lo != 2'b00);
      default:    misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_cpu_master.sv
// Non-pipelined AHB initiator bridging a CPU req/ack load/store port to single transfers.
// Optional macro AHB_MST_POSTED_WR_EN: stores are acked early and bus failures flag posted_err.
module ahb_cpu_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = AHB_ADDR_BITS,
  parameter int unsigned DATA_W    = AHB_DATA_BITS,
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [2:0]        cpu_size,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              posted_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP
);

  localparam int unsigned RC_W = $clog2(MAX_RETRY + 1);
  localparam logic [RC_W-1:0] RETRY_LIM = RC_W'(MAX_RETRY);

  mst_state_e        state;
  logic [RC_W-1:0]   retry_cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              misaligned;
  logic              accept;
  logic              bad_req;
  logic              done;
  logic              fail;
  logic              posted_q;
  logic              early_ack;

  ahb_mst_align_chk u_align (
    .size       (cpu_size),
    .addr_lo    (cpu_addr[1:0]),
    .misaligned (misaligned)
  );

  assign HBURST  = HBURST_SINGLE;
  // cpu_req is ignored while the previous ack is still on the wire
  assign accept  = (state == ST_IDLE) && cpu_req && !cpu_ack && !misaligned;
  assign bad_req = (state == ST_IDLE) && cpu_req && !cpu_ack &&  misaligned;

  always_comb begin
    done = 1'b0;
    fail = 1'b0;
    case (state)
      ST_DATA: if (HREADY) begin
        done = 1'b1;
        fail = (HRESP != HRESP_OKAY);
      end
      ST_ERR2: if (HREADY) begin
        done = 1'b1;
        fail = 1'b1;
      end
      ST_RTRY: if (HREADY && (retry_cnt >= RETRY_LIM)) begin
        done = 1'b1;
        fail = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef AHB_MST_POSTED_WR_EN
  assign early_ack = cpu_we;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      posted_q   <= 1'b0;
      posted_err <= 1'b0;
    end else begin
      if (accept)
        posted_q <= cpu_we;
      if (done && posted_q && fail)
        posted_err <= 1'b1;
    end
  end
`else
  assign early_ack  = 1'b0;
  assign posted_q   = 1'b0;
  assign posted_err = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      retry_cnt <= '0;
      wdata_q   <= '0;
      HADDR     <= '0;
      HTRANS    <= HTRANS_IDLE;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      HWDATA    <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          HTRANS <= HTRANS_IDLE;
          if (bad_req) begin
            cpu_ack <= 1'b1;
            cpu_err <= 1'b1;
          end else if (accept) begin
            HADDR   <= cpu_addr;
            HWRITE  <= cpu_we;
            HSIZE   <= cpu_size;
            wdata_q <= cpu_wdata;
            HTRANS  <= HTRANS_NONSEQ;
            cpu_ack <= early_ack;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: if (HREADY) begin
          HTRANS <= HTRANS_IDLE;
          HWDATA <= wdata_q;
          state  <= ST_DATA;
        end
        ST_DATA: begin
          if (done)
            state <= ST_IDLE;
          else if (HRESP == HRESP_ERROR)
            state <= ST_ERR2;
          else if (HRESP != HRESP_OKAY)
            state <= ST_RTRY;
        end
        ST_ERR2: if (done) state <= ST_IDLE;
        // Second RETRY/SPLIT cycle: re-issue the same address phase while budget remains
        ST_RTRY: if (HREADY) begin
          if (done) begin
            state <= ST_IDLE;
          end else begin
            retry_cnt <= retry_cnt + 1'b1;
            HTRANS    <= HTRANS_NONSEQ;
            state     <= ST_ADDR;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (done) begin
        retry_cnt <= '0;
        if (!posted_q) begin
          cpu_ack <= 1'b1;
          cpu_err <= fail;
          if (!HWRITE && !fail)
            cpu_rdata <= HRDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_cpu_master.sv
// Directed table-driven bench for ahb_cpu_master with a scripted AHB slave in the loop.
module tb_ahb_cpu_master;
  import ahb_pkg::*;

`ifdef AHB_MST_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  localparam logic [31:0] JUNK = 32'hBAD0_0000;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cpu_req, cpu_we, cpu_ack, cpu_err, posted_err;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_size;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;

  ahb_cpu_master #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .posted_err(posted_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          waits;
    int          n_retry;
    bit          err_resp;
    logic [31:0] rdata;
    int          exp_ack_cyc;
    bit          exp_err;
    int          exp_nonseq;
  } vec_t;

  vec_t        vecs[12];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          cyc = 0, idx = 0, nonseq = 0, ack_cyc = -1, extra = 0;
    int          retries_left = v.n_retry, bad_ctrl = 0, bad_wd = 0;
    int          exp_ack = v.exp_ack_cyc;
    bit          dp = 0, dp_next = 0, exp_err = v.exp_err;
    logic        err_s = 1'b0;
    logic [31:0] rd_s = '0;
    logic [1:0]  rsp;
    if (POSTED && v.we && v.exp_nonseq > 0) begin
      exp_ack = 1;
      exp_err = 1'b0;
    end
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_size = v.size; cpu_wdata = v.wdata;
    HREADY = 1'b1; HRESP = HRESP_OKAY; HRDATA = JUNK;
    while ((ack_cyc < 0 || dp || dp_next) && cyc < 100) begin
      @(negedge HCLK);
      cyc++;
      if (cpu_ack) begin
        if (ack_cyc < 0) begin
          ack_cyc = cyc; err_s = cpu_err; rd_s = cpu_rdata;
        end else extra++;
        cpu_req = 1'b0;
      end
      if (dp_next) begin dp = 1; idx = 0; dp_next = 0; end
      HREADY = 1'b1; HRESP = HRESP_OKAY; HRDATA = JUNK;
      if (HTRANS == HTRANS_NONSEQ) begin
        nonseq++;
        dp_next = 1;
        if (HADDR !== v.addr || HWRITE !== v.we || HSIZE !== v.size || HBURST !== 3'b000)
          bad_ctrl++;
      end
      if (dp) begin
        if (v.we && HWDATA !== v.wdata) bad_wd++;
        if (HTRANS != HTRANS_IDLE) bad_ctrl++;
        if (idx < v.waits) HREADY = 1'b0;
        else begin
          rsp = (retries_left > 0) ? HRESP_RETRY : (v.err_resp ? HRESP_ERROR : HRESP_OKAY);
          if (rsp == HRESP_OKAY) begin
            HRDATA = v.rdata;
            dp = 0;
          end else begin
            HRESP  = rsp;
            HREADY = (idx > v.waits);
            if (HREADY) begin
              dp = 0;
              if (rsp == HRESP_RETRY) retries_left--;
            end
          end
        end
        idx++;
      end
    end
    repeat (2) begin
      @(negedge HCLK);
      if (cpu_ack) extra++;
      HREADY = 1'b1; HRESP = HRESP_OKAY;
    end
    cpu_req = 1'b0;
    if (!v.we && !exp_err && v.exp_nonseq > 0) last_rdata = v.rdata;
    chk($sformatf("v%0d ack_cycle", id), ack_cyc, exp_ack);
    chk($sformatf("v%0d cpu_err", id), {31'b0, err_s}, {31'b0, exp_err});
    chk($sformatf("v%0d cpu_rdata", id), rd_s, last_rdata);
    chk($sformatf("v%0d nonseq_count", id), nonseq, v.exp_nonseq);
    chk($sformatf("v%0d addr_ctrl_bad", id), bad_ctrl, 0);
    chk($sformatf("v%0d extra_acks", id), extra, 0);
    if (v.we) chk($sformatf("v%0d hwdata_bad", id), bad_wd, 0);
  endtask

  initial begin
    int acks;
    //           we    addr           size    wdata          wt rt err  rdata          ack err ns
    vecs[0]  = '{1'b0, 32'h0000_0100, 3'b010, 32'h0,         0, 0, 0, 32'hDEAD_BEEF,  3, 0, 1};
    vecs[1]  = '{1'b1, 32'h0000_0040, 3'b010, 32'h1234_5678, 2, 0, 0, 32'h0,          5, 0, 1};
    vecs[2]  = '{1'b0, 32'h0000_0203, 3'b000, 32'h0,         1, 0, 0, 32'h0000_00A5,  4, 0, 1};
    vecs[3]  = '{1'b0, 32'h0000_0302, 3'b001, 32'h0,         0, 0, 0, 32'h0000_1234,  3, 0, 1};
    vecs[4]  = '{1'b0, 32'h0000_0080, 3'b010, 32'h0,         0, 0, 1, 32'h1111_1111,  4, 1, 1};
    vecs[5]  = '{1'b0, 32'h0000_0500, 3'b010, 32'h0,         0, 5, 0, 32'h2222_2222, 16, 1, 5};
    vecs[6]  = '{1'b0, 32'h0000_0504, 3'b010, 32'h0,         0, 2, 0, 32'hCAFE_F00D,  9, 0, 3};
    vecs[7]  = '{1'b1, 32'h0000_0102, 3'b010, 32'h5555_AAAA, 0, 0, 0, 32'h0,          1, 1, 0};
    vecs[8]  = '{1'b0, 32'h0000_0301, 3'b001, 32'h0,         0, 0, 0, 32'h3333_3333,  1, 1, 0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 3'b011, 32'h0,         0, 0, 0, 32'h4444_4444,  1, 1, 0};
    vecs[10] = '{1'b1, 32'h0000_0600, 3'b010, 32'h0BAD_F00D, 0, 0, 1, 32'h0,          4, 1, 1};
    vecs[11] = '{1'b1, 32'h0000_0007, 3'b000, 32'h0000_00AB, 0, 0, 0, 32'h0,          3, 0, 1};

    HRESETn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_size = '0; cpu_wdata = '0;
    HREADY = 1'b1; HRESP = HRESP_OKAY; HRDATA = JUNK;
    repeat (2) @(negedge HCLK);
    chk("rst HTRANS", {30'b0, HTRANS}, 32'h0);
    chk("rst HADDR", HADDR, 32'h0);
    chk("rst HWDATA", HWDATA, 32'h0);
    chk("rst HSIZE_HWRITE_HBURST", {25'b0, HSIZE, HWRITE, HBURST}, 32'h0);
    chk("rst cpu_ack_err_perr", {29'b0, cpu_ack, cpu_err, posted_err}, 32'h0);
    chk("rst cpu_rdata", cpu_rdata, 32'h0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
    chk("posted_err sticky", {31'b0, posted_err}, {31'b0, POSTED});

    // Misaligned request held high: ack cycle ignores it, re-accept one cycle later
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0001; cpu_size = 3'b010;
    acks = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge HCLK);
      if (cpu_ack) acks++;
      if (c == 2) chk("held_req gap cycle ack", {31'b0, cpu_ack}, 32'h0);
      if (c == 4) cpu_req = 1'b0;
    end
    chk("held_req ack_count", acks, 2);
    repeat (2) @(negedge HCLK);

    // Reset asserted while the data phase is in a wait state
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100; cpu_size = 3'b010;
    @(negedge HCLK);
    chk("rstmid nonseq", {30'b0, HTRANS}, {30'b0, HTRANS_NONSEQ});
    HREADY = 1'b1;
    @(negedge HCLK);
    HREADY = 1'b0;
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    chk("rstmid HTRANS", {30'b0, HTRANS}, 32'h0);
    chk("rstmid HADDR", HADDR, 32'h0);
    chk("rstmid cpu_ack", {31'b0, cpu_ack}, 32'h0);
    chk("rstmid cpu_rdata", cpu_rdata, 32'h0);
    cpu_req = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1; HREADY = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge HCLK);
      if (cpu_ack || HTRANS != HTRANS_IDLE) acks++;
    end
    chk("rstmid no_ack_after", acks, 0);
    chk("rstmid posted_err", {31'b0, posted_err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
